// File: rtl/sub4u_serial.sv
// Bit-serial unsigned subtractor: computes a - b LSB-first, one bit per clock,
// with valid/ready handshakes on both the operand and result sides.
//
// state | meaning
// IDLE  | waiting for an operand pair (in_ready=1)
// RUN   | one difference bit per clock, WIDTH clocks
// DONE  | result presented (out_valid=1) until out_ready
module sub4u_serial #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-2:0] d_sh;
    logic             br;
    logic [CW-1:0]    cnt;

    logic [WIDTH-1:0] diff_q;
    logic             borrow_q;
    logic             zero_q;

    logic             accept;
    logic             drain;
    logic             last_bit;
    logic             d_bit;
    logic             br_nxt;
    logic [WIDTH-1:0] d_full;

    assign accept   = in_valid & (state == IDLE);
    assign drain    = out_ready & (state == DONE);
    assign last_bit = (cnt == CW'(WIDTH - 1));

    // Full-subtractor cell on the current LSBs.
    assign d_bit  = a_sh[0] ^ b_sh[0] ^ br;
    assign br_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & br);
    assign d_full = {d_bit, d_sh};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_bit) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (drain) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Result registers are loaded only on the final RUN edge, so the previous
    // result stays visible while the next one is being computed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh     <= '0;
            b_sh     <= '0;
            d_sh     <= '0;
            br       <= 1'b0;
            cnt      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            d_sh <= '0;
            br   <= 1'b0;
            cnt  <= '0;
        end else if (state == RUN) begin
            a_sh <= a_sh >> 1;
            b_sh <= b_sh >> 1;
            d_sh <= d_full[WIDTH-1:1];
            br   <= br_nxt;
            cnt  <= cnt + CW'(1);
            if (last_bit) begin
                diff_q   <= d_full;
                borrow_q <= br_nxt;
                zero_q   <= (d_full == '0);
            end
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign zero      = zero_q;

endmodule
